// File: rtl/capture_scheduler_pkg.sv
// Shared types and helpers for the switch-capture scheduler.
// State encoding, requester indices, datapath widths, arbitration and saturation helpers.
package capture_scheduler_pkg;

   localparam int DATA_W = 10;
   localparam int CNT_W  = 8;

   localparam logic SRC_BTN  = 1'b0;
   localparam logic SRC_AUTO = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_HOLD = 2'd2
   } state_t;

   // A lone requester always wins; on a tie the one that did not win last time goes.
   function automatic logic pick_winner(input logic [1:0] pend, input logic last_src);
      logic win;
      case (pend)
         2'b01:   win = SRC_BTN;
         2'b10:   win = SRC_AUTO;
         default: win = ~last_src;
      endcase
      return win;
   endfunction

   function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
      logic [CNT_W:0] sum;
      sum = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
      return sum[CNT_W] ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
   endfunction

endpackage

// File: rtl/capture_scheduler_tick_gen.sv
// Auto-capture prescaler: counts 0..AUTO_PERIOD-1 while enabled, tick on the last count.
// Disabling clears the count so a re-enable waits a full period for its first tick.
module capture_scheduler_tick_gen #(
   parameter int AUTO_PERIOD = 100000000
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic en_i,
   output logic tick_o
);

   localparam int            CW   = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
   localparam logic [CW-1:0] LAST = CW'(AUTO_PERIOD - 1);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (!en_i) begin
         cnt_d = '0;
      end else if (cnt_q == LAST) begin
         cnt_d = '0;
      end else begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign tick_o = en_i && (cnt_q == LAST);

endmodule

// File: rtl/capture_scheduler.sv
// Round-robin capture scheduler: button and periodic auto requests share one switch-capture load.
// Request to load strobe is two edges; each load is followed by HOLD_CYCLES busy cycles.
module capture_scheduler
   import capture_scheduler_pkg::*;
#(
   parameter int AUTO_PERIOD = 100000000,
   parameter int HOLD_CYCLES = 16
) (
   input  logic              clk100_i,
   input  logic              rst_i,
   input  logic [DATA_W-1:0] sw_i,
   input  logic              bt_pulse_i,
   input  logic              auto_en_i,
   output logic              load_o,
   output logic              src_o,
   output logic [DATA_W-1:0] ledr_o,
   output logic [CNT_W-1:0]  cntr_o,
   output logic [CNT_W-1:0]  drop_o,
   output logic              busy_o
);

   localparam int            HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [HW-1:0] HOLD_LAST = HW'((HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0);

   state_t            state_q;
   logic [1:0]        pend_q;
   logic [1:0]        pend_d;
   logic              last_src_q;
   logic [HW-1:0]     hold_cnt_q;
   logic              load_q;
   logic              busy_q;
   logic              src_q;
   logic [DATA_W-1:0] ledr_q;
   logic [CNT_W-1:0]  cntr_q;
   logic [CNT_W-1:0]  drop_q;
   logic [CNT_W-1:0]  drop_d;

   logic       auto_tick;
   logic [1:0] req;
   logic       grant;
   logic       grant_src;
   logic [1:0] clr;
   logic [1:0] drop_vec;
   logic [1:0] ndrop;

   capture_scheduler_tick_gen #(
      .AUTO_PERIOD(AUTO_PERIOD)
   ) u_tick_gen (
      .clk_i (clk100_i),
      .rst_i (rst_i),
      .en_i  (auto_en_i),
      .tick_o(auto_tick)
   );

   // A same-cycle request and grant-clear leave the bit set and are not counted as a drop.
   always_comb begin
      req       = {auto_tick, bt_pulse_i};
      grant     = (state_q == ST_IDLE) && (pend_q != 2'b00);
      grant_src = pick_winner(pend_q, last_src_q);
      clr       = 2'b00;
      if (grant) begin
         clr[grant_src] = 1'b1;
      end
      drop_vec = req & pend_q & ~clr;
      pend_d   = (pend_q & ~clr) | req;
      ndrop    = {1'b0, drop_vec[0]} + {1'b0, drop_vec[1]};
      drop_d   = sat_add(drop_q, ndrop);
   end

   always_ff @(posedge clk100_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         pend_q     <= 2'b00;
         last_src_q <= SRC_AUTO;
         hold_cnt_q <= '0;
         load_q     <= 1'b0;
         busy_q     <= 1'b0;
         src_q      <= 1'b0;
         ledr_q     <= '0;
         cntr_q     <= '0;
         drop_q     <= '0;
      end else begin
         pend_q <= pend_d;
         drop_q <= drop_d;
         load_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (grant) begin
                  state_q    <= ST_LOAD;
                  load_q     <= 1'b1;
                  busy_q     <= 1'b1;
                  src_q      <= grant_src;
                  last_src_q <= grant_src;
               end
            end
            ST_LOAD: begin
               ledr_q     <= sw_i;
               cntr_q     <= cntr_q + CNT_W'(1);
               hold_cnt_q <= '0;
               if (HOLD_CYCLES > 0) begin
                  state_q <= ST_HOLD;
               end else begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end
            end
            ST_HOLD: begin
               if (hold_cnt_q == HOLD_LAST) begin
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else begin
                  hold_cnt_q <= hold_cnt_q + HW'(1);
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign load_o = load_q;
   assign src_o  = src_q;
   assign ledr_o = ledr_q;
   assign cntr_o = cntr_q;
   assign drop_o = drop_q;
   assign busy_o = busy_q;

endmodule
